rd_req_splitter: RTL
====================

# rd_req_splitter

Converts decompression read jobs popped from the working job FIFO into page-safe, beat-aligned memory read requests. Each job (source address, byte length, job ID) is split into bursts that never exceed a maximum beat count or cross a page boundary. For every issued burst it pushes the job ID into the read-tag FIFO, which is consumed alongside returned read data. It stalls while that FIFO reports almost-full.

## Interface
Parameters:
- BEAT_LOG2, 6: log2 of bytes per data beat (64 B).
- MAX_BEATS, 64: maximum beats per request; power of two, ≤ 2^(PAGE_LOG2-BEAT_LOG2), ≤ 256.
- PAGE_LOG2, 12: log2 of the no-cross boundary (4 KiB).

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- job_valid  in  1  job-FIFO head valid.
- job_rd_length  in  26  job length in bytes.
- job_src_addr  in  64  job byte address.
- job_id  in  16  job identifier.
- job_rd  out  1  pop job-FIFO head; combinational.
- req_valid  out  1  read request valid.
- req_ready  in  1  read request accepted.
- req_addr  out  64  beat-aligned burst address.
- req_len  out  8  beats minus one.
- tag_wr  out  1  push to read-tag FIFO.
- tag_job_id  out  16  ID pushed with tag_wr.
- tag_almost_full  in  1  read-tag FIFO programmable-full.
- job_done  out  1  one-cycle pulse, job fully issued.
- job_done_id  out  16  ID qualified by job_done.
- busy  out  1  state ≠ IDLE.
- stat_jobs  out  32  jobs completed (see Configuration).
- stat_reqs  out  32  requests issued (see Configuration).

## Operation
- FSM states: IDLE, CALC, ISSUE.
- IDLE:
  - job_rd = job_valid & ~srst.
  - On a pop, capture the job:
    - cur_addr = src_addr with the low BEAT_LOG2 bits cleared.
    - rem_beats (21 b) = ceil((src_addr[BEAT_LOG2-1:0] + rd_length) / 2^BEAT_LOG2).
    - id = job_id.
  - If rd_length == 0: next state IDLE, job_done pulses next cycle, no request and no tag. Otherwise next state CALC.
- CALC: compute and register beats = min(rem_beats, MAX_BEATS, beats from cur_addr to the next 2^PAGE_LOG2 boundary). Next state ISSUE.
- ISSUE:
  - req_valid rises only while tag_almost_full = 0. Once high, it stays high with req_addr/req_len stable until req_ready, regardless of tag_almost_full.
  - req_addr = cur_addr; req_len = beats − 1.
  - Handshake (req_valid & req_ready):
    - tag_wr = 1 in the same cycle, with tag_job_id = id.
    - cur_addr += beats << BEAT_LOG2; rem_beats −= beats.
    - If the new rem_beats = 0: go to IDLE and register job_done / job_done_id = id. Otherwise go to CALC.
- Address arithmetic wraps modulo 2^64; there is no error for wrap.
- Exactly one tag per request, pushed in request order.

## Timing
- Reset values:
  - state IDLE.
  - job_rd, req_valid, tag_wr, job_done, busy = 0.
  - req_addr, req_len, tag_job_id, job_done_id = 0.
  - Stat counters = 0.
- Job popped at cycle T → CALC at T+1 → earliest req_valid at T+2.
- Handshake at H with more beats remaining → CALC at H+1, next req_valid at H+2.
- Final handshake at H → job_done at H+1, IDLE at H+1, next job_rd possible at H+1.
- Zero-length job popped at T → job_done at T+1, IDLE throughout.
- srst mid-job: req_valid and tag_wr drop the next cycle. The current job is abandoned with no job_done, and the FIFO head is not re-read.
- tag_wr is never asserted without a same-cycle request handshake.

## Configuration
- RD_REQ_SPLITTER_STATS_EN defined:
  - stat_jobs increments on each job_done.
  - stat_reqs increments on each handshake.
  - Both are 32-bit, wrap, and are cleared by srst.
- Undefined: both ports tied to 0 and no counter logic is generated. Request behaviour is identical either way.

## Test plan
- src_addr 0x1000, length 256, id 0x0011 → one request: addr 0x1000, len 3. One tag 0x0011. job_done with id 0x0011.
- src_addr 0x0FC0, length 128 → page split into two requests: 0x0FC0 len 0, then 0x1000 len 0. Two tags.
- src_addr 0x0010, length 64 → unaligned case: one request, addr 0x0000, len 1.
- src_addr 0x2000, length 8192, MAX_BEATS 64 → two requests: 0x2000 len 63 and 0x3000 len 63. With STATS_EN, stat_reqs = 2 and stat_jobs = 1.
- Back-pressure checks:
  - tag_almost_full held high for 10 cycles → req_valid stays 0. Releasing it → request at the next ISSUE cycle.
  - req_ready low for 5 cycles → addr/len stable and no tag_wr until the handshake.
- Edge cases:
  - Zero-length job → a single job_rd pulse, no req_valid, job_done next cycle.
  - srst asserted during ISSUE → all outputs at reset values the next cycle, busy = 0.

Source files
------------

// File: rtl/rd_req_splitter.sv
// rd_req_splitter
//   Turns decompression read jobs from the working job FIFO into memory read
//   bursts. Each burst is beat-aligned and is limited to MAX_BEATS beats. No
//   burst crosses a 2^PAGE_LOG2 byte boundary. Every accepted burst pushes
//   the job ID into the read-tag FIFO. A new burst is not raised while that
//   FIFO reports almost-full.
//
// Ports
//   clk, srst                     clock, synchronous active-high reset
//   job_valid/job_rd              job FIFO head valid / pop (combinational)
//   job_rd_length/src_addr/id     job fields at the FIFO head
//   req_valid/req_ready           read request handshake
//   req_addr, req_len             burst byte address, beats minus one
//   tag_wr, tag_job_id            read-tag FIFO push (same cycle as handshake)
//   tag_almost_full               read-tag FIFO programmable-full
//   job_done, job_done_id         one-cycle pulse when a job is fully issued
//   busy                          FSM not idle
//   stat_jobs, stat_reqs          completion / request counters
//
// Build option
//   RD_REQ_SPLITTER_STATS_EN      when defined, stat_jobs and stat_reqs count
//                                 up. Otherwise both outputs are tied to zero.
module rd_req_splitter #(
  parameter int BEAT_LOG2 = 6,
  parameter int MAX_BEATS = 64,
  parameter int PAGE_LOG2 = 12
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        job_valid,
  input  logic [25:0] job_rd_length,
  input  logic [63:0] job_src_addr,
  input  logic [15:0] job_id,
  output logic        job_rd,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  output logic [7:0]  req_len,
  output logic        tag_wr,
  output logic [15:0] tag_job_id,
  input  logic        tag_almost_full,
  output logic        job_done,
  output logic [15:0] job_done_id,
  output logic        busy,
  output logic [31:0] stat_jobs,
  output logic [31:0] stat_reqs
);

  // Offset + length + rounding term fits in 27 bits. Beat count is the rest.
  localparam int SUM_W    = 27;
  localparam int REM_W    = SUM_W - BEAT_LOG2;
  localparam int PG_BEATS = 1 << (PAGE_LOG2 - BEAT_LOG2);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  state_t             r_state;
  logic [63:0]        r_cur_addr;
  logic [REM_W-1:0]   r_rem;
  logic [15:0]        r_id;
  logic [7:0]         r_len;
  logic               r_hold;
  logic               r_job_done;
  logic [15:0]        r_done_id;

  logic [SUM_W-1:0]               w_sum;
  logic [REM_W-1:0]               w_rem0;
  logic [PAGE_LOG2-BEAT_LOG2-1:0] w_page_idx;
  logic [REM_W-1:0]               w_to_page;
  logic [REM_W-1:0]               w_beats;
  logic [REM_W-1:0]               w_cur_beats;
  logic [63:0]                    w_step;
  logic                           w_req_valid;
  logic                           w_hs;

  function automatic logic [REM_W-1:0] min_beats(input logic [REM_W-1:0] a,
                                                 input logic [REM_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Total beats touched by the job, counting the partial first beat.
  assign w_sum  = SUM_W'(job_src_addr[BEAT_LOG2-1:0]) + SUM_W'(job_rd_length)
                + SUM_W'((1 << BEAT_LOG2) - 1);
  assign w_rem0 = REM_W'(w_sum >> BEAT_LOG2);

  // Beats left before the next page boundary.
  assign w_page_idx = r_cur_addr[PAGE_LOG2-1:BEAT_LOG2];
  assign w_to_page  = REM_W'(PG_BEATS) - REM_W'(w_page_idx);
  assign w_beats    = min_beats(min_beats(r_rem, REM_W'(MAX_BEATS)), w_to_page);

  assign w_cur_beats = REM_W'({1'b0, r_len}) + REM_W'(1);
  assign w_step      = 64'(w_cur_beats) << BEAT_LOG2;

  // Once raised, valid holds until accepted even if almost-full returns.
  assign w_req_valid = (r_state == ISSUE) && (r_hold || !tag_almost_full);
  assign w_hs        = w_req_valid && req_ready;

  assign job_rd      = (r_state == IDLE) && job_valid && !srst;
  assign req_valid   = w_req_valid;
  assign req_addr    = r_cur_addr;
  assign req_len     = r_len;
  assign tag_wr      = w_hs;
  assign tag_job_id  = r_id;
  assign job_done    = r_job_done;
  assign job_done_id = r_done_id;
  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state    <= IDLE;
      r_cur_addr <= '0;
      r_rem      <= '0;
      r_id       <= '0;
      r_len      <= '0;
      r_hold     <= 1'b0;
      r_job_done <= 1'b0;
      r_done_id  <= '0;
    end else begin
      r_job_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (job_valid) begin
            r_cur_addr <= {job_src_addr[63:BEAT_LOG2], {BEAT_LOG2{1'b0}}};
            r_rem      <= w_rem0;
            r_id       <= job_id;
            if (job_rd_length == '0) begin
              r_job_done <= 1'b1;
              r_done_id  <= job_id;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_len   <= 8'(w_beats - REM_W'(1));
          r_hold  <= 1'b0;
          r_state <= ISSUE;
        end
        ISSUE: begin
          if (w_hs) begin
            r_cur_addr <= r_cur_addr + w_step;
            r_rem      <= r_rem - w_cur_beats;
            r_hold     <= 1'b0;
            if (r_rem == w_cur_beats) begin
              r_state    <= IDLE;
              r_job_done <= 1'b1;
              r_done_id  <= r_id;
            end else begin
              r_state <= CALC;
            end
          end else if (w_req_valid) begin
            r_hold <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RD_REQ_SPLITTER_STATS_EN
  logic [31:0] r_stat_jobs;
  logic [31:0] r_stat_reqs;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_stat_jobs <= '0;
      r_stat_reqs <= '0;
    end else begin
      if (r_job_done) r_stat_jobs <= r_stat_jobs + 32'd1;
      if (w_hs)       r_stat_reqs <= r_stat_reqs + 32'd1;
    end
  end

  assign stat_jobs = r_stat_jobs;
  assign stat_reqs = r_stat_reqs;
`else
  assign stat_jobs = '0;
  assign stat_reqs = '0;
`endif

endmodule
